// File: rtl/seven_seg_scan_ctrl_if.sv
// Wishbone slave bundle for seven_seg_scan_ctrl.
// The bus master drives the request half; the scan controller returns ack and read data.
interface seven_seg_scan_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with Wishbone register window and PWM dimming.
// Optional SEVEN_SEG_SHADOW_EN latches DATA/DP at each frame start to avoid tearing.
module seven_seg_scan_ctrl #(
    parameter logic [31:0] ADDR_BASE    = 32'h3000_0010,
    parameter int          NUM_DIGITS   = 4,
    parameter int          BLANK_CYCLES = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    seven_seg_scan_ctrl_if.slave  wbs,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] digit_en
);
    // IDLE: outputs off, idx 0 | DWELL: current digit lit | BLANK: all off between digits
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DWELL = 2'd1, S_BLANK = 2'd2} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_en, r_inv;
    logic [3:0]  r_bright;
    logic [15:0] r_period, w_period_eff;
    logic [31:0] r_data, w_data_nxt, w_data_src;
    logic [7:0]  r_dp, w_dp_nxt, w_dp_src;
    logic [15:0] r_dcnt, w_dcnt_nxt;
    logic [3:0]  r_bcnt, w_bcnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_frame, w_frame_nxt;
    logic [3:0]  r_pwm;
    logic        r_ack;
    logic [31:0] r_dat, w_rd;
    logic [31:0] w_off;
    logic [2:0]  w_word;
    logic        w_hit, w_acc, w_wr;
    logic [6:0]  w_seg_o;
    logic        w_dp_o;
    logic [NUM_DIGITS-1:0] w_en_o;
    logic [3:0]  w_nib;

    assign w_off  = wbs.wbs_adr_i - ADDR_BASE;
    assign w_hit  = (w_off < 32'h14) && (w_off[1:0] == 2'b00);
    assign w_word = w_off[4:2];
    // ack low is the only window in which a new access can be taken
    assign w_acc  = wbs.wbs_cyc_i & wbs.wbs_stb_i & w_hit & ~r_ack;
    assign w_wr   = w_acc & wbs.wbs_we_i;

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;

    always_comb begin
        w_data_nxt = r_data;
        w_dp_nxt   = r_dp;
        if (w_wr && w_word == 3'd2) begin
            for (int i = 0; i < 4; i++) begin
                if (wbs.wbs_sel_i[i]) w_data_nxt[8*i +: 8] = wbs.wbs_dat_i[8*i +: 8];
            end
        end
        if (w_wr && w_word == 3'd3 && wbs.wbs_sel_i[0]) w_dp_nxt = wbs.wbs_dat_i[7:0];
    end

    always_comb begin
        w_rd = '0;
        case (w_word)
            3'd0:    w_rd = {20'h0, r_bright, 6'h0, r_inv, r_en};
            3'd1:    w_rd = {16'h0, r_period};
            3'd2:    w_rd = r_data;
            3'd3:    w_rd = {24'h0, r_dp};
            3'd4:    w_rd = {16'h0, r_frame, 3'b000, r_state, r_idx};
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_en     <= 1'b0;
            r_inv    <= 1'b0;
            r_bright <= '0;
            r_period <= '0;
            r_data   <= '0;
            r_dp     <= '0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_pwm    <= '0;
        end else begin
            r_ack  <= w_acc;
            r_dat  <= (w_acc && !wbs.wbs_we_i) ? w_rd : 32'h0;
            r_pwm  <= r_pwm + 4'd1;
            r_data <= w_data_nxt;
            r_dp   <= w_dp_nxt;
            if (w_wr && w_word == 3'd0) begin
                if (wbs.wbs_sel_i[0]) begin
                    r_en  <= wbs.wbs_dat_i[0];
                    r_inv <= wbs.wbs_dat_i[1];
                end
                if (wbs.wbs_sel_i[1]) r_bright <= wbs.wbs_dat_i[11:8];
            end
            if (w_wr && w_word == 3'd1) begin
                if (wbs.wbs_sel_i[0]) r_period[7:0]  <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) r_period[15:8] <= wbs.wbs_dat_i[15:8];
            end
        end
    end

    assign w_period_eff = (r_period == 16'd0) ? 16'd1 : r_period;

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_bcnt_nxt  = r_bcnt;
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame;
        if (!r_en) begin
            w_state_nxt = S_IDLE;
            w_dcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_DWELL;
                    w_dcnt_nxt  = '0;
                    w_idx_nxt   = '0;
                end
                S_DWELL: begin
                    // compare against live PERIOD so a shrink mid-dwell ends it at once
                    if ({1'b0, r_dcnt} + 17'd1 >= {1'b0, w_period_eff}) begin
                        w_state_nxt = S_BLANK;
                        w_dcnt_nxt  = '0;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_dcnt_nxt = r_dcnt + 16'd1;
                    end
                end
                S_BLANK: begin
                    if (r_bcnt == 4'(BLANK_CYCLES - 1)) begin
                        w_state_nxt = S_DWELL;
                        w_bcnt_nxt  = '0;
                        if (r_idx == 3'(NUM_DIGITS - 1)) begin
                            w_idx_nxt   = '0;
                            w_frame_nxt = r_frame + 8'd1;
                        end else begin
                            w_idx_nxt = r_idx + 3'd1;
                        end
                    end else begin
                        w_bcnt_nxt = r_bcnt + 4'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_dcnt  <= '0;
            r_bcnt  <= '0;
            r_idx   <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_idx   <= w_idx_nxt;
            r_frame <= w_frame_nxt;
        end
    end

`ifdef SEVEN_SEG_SHADOW_EN
    logic [31:0] r_data_sh;
    logic [7:0]  r_dp_sh;
    logic        w_load_sh;

    // takes the post-write value so a write on the frame-start edge lands in this frame
    assign w_load_sh = (w_state_nxt == S_DWELL) && (r_state != S_DWELL) && (w_idx_nxt == 3'd0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_data_sh <= '0;
            r_dp_sh   <= '0;
        end else if (w_load_sh) begin
            r_data_sh <= w_data_nxt;
            r_dp_sh   <= w_dp_nxt;
        end
    end

    assign w_data_src = r_data_sh;
    assign w_dp_src   = r_dp_sh;
`else
    assign w_data_src = r_data;
    assign w_dp_src   = r_dp;
`endif

    always_comb begin
        w_nib   = w_data_src[{r_idx, 2'b00} +: 4];
        w_seg_o = '0;
        w_dp_o  = 1'b0;
        w_en_o  = '0;
        if (r_state == S_DWELL) begin
            w_en_o = NUM_DIGITS'(1) << r_idx;
            if (r_pwm <= r_bright) begin
                w_dp_o = w_dp_src[r_idx];
                case (w_nib)
                    4'h0: w_seg_o = 7'b0111111;
                    4'h1: w_seg_o = 7'b0000110;
                    4'h2: w_seg_o = 7'b1011011;
                    4'h3: w_seg_o = 7'b1001111;
                    4'h4: w_seg_o = 7'b1100110;
                    4'h5: w_seg_o = 7'b1101101;
                    4'h6: w_seg_o = 7'b1111101;
                    4'h7: w_seg_o = 7'b0000111;
                    4'h8: w_seg_o = 7'b1111111;
                    4'h9: w_seg_o = 7'b1101111;
                    4'hA: w_seg_o = 7'b1110111;
                    4'hB: w_seg_o = 7'b1111100;
                    4'hC: w_seg_o = 7'b0111001;
                    4'hD: w_seg_o = 7'b1011110;
                    4'hE: w_seg_o = 7'b1111001;
                    default: w_seg_o = 7'b1110001;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            seg_out  <= '0;
            dp_out   <= 1'b0;
            digit_en <= '0;
        end else begin
            seg_out  <= w_seg_o ^ {7{r_inv}};
            dp_out   <= w_dp_o ^ r_inv;
            digit_en <= w_en_o ^ {NUM_DIGITS{r_inv}};
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: bus reads and per-cycle display samples are
// queued as expectations when stimulus is issued and compared when the DUT produces them.
module tb_seven_seg_scan_ctrl;
    localparam logic [31:0] BASE   = 32'h3000_0010;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PER  = BASE + 32'h4;
    localparam logic [31:0] A_DATA = BASE + 32'h8;
    localparam logic [31:0] A_DP   = BASE + 32'hC;
    localparam logic [31:0] A_STAT = BASE + 32'h10;
    localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [3:0] digit_en;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int c0       = 0;

    typedef struct {
        int          k;
        logic [11:0] exp;
    } disp_t;

    disp_t       dq[$];
    logic [31:0] rd_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    seven_seg_scan_ctrl_if wb();

    seven_seg_scan_ctrl #(.ADDR_BASE(BASE), .NUM_DIGITS(4), .BLANK_CYCLES(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (wb),
        .seg_out  (seg_out),
        .dp_out   (dp_out),
        .digit_en (digit_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'h0;
        wb.wbs_dat_i = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bit got;
        got = 1'b0;
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            got = wb.wbs_ack_o;
        end
        bus_idle();
        chk($sformatf("wr_ack_%0h", adr), 32'(got), 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        bit got;
        got = 1'b0;
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_adr_i = adr;
        rd_q.push_back(exp);
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            got = wb.wbs_ack_o;
        end
        bus_idle();
        if (got) chk(tag, wb.wbs_dat_o, rd_q.pop_front());
        else begin
            chk({tag, "_ack"}, 32'd0, 32'd1);
            void'(rd_q.pop_front());
        end
    endtask

    // sample k is taken 1 time unit after the k-th edge following the marked write's ack edge
    task automatic wait_k(input int k);
        while (cyc_cnt < c0 + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [11:0] exp_out(input int k, input logic [15:0] data, input logic [3:0] dp,
                                            input int per, input bit inv);
        int         m;
        int         d;
        logic [3:0] en;
        logic [6:0] sg;
        logic       db;
        m  = k - 2;
        en = '0;
        sg = '0;
        db = 1'b0;
        if (m >= 0 && (m % (per + 2)) < per) begin
            d  = (m / (per + 2)) % 4;
            en = 4'(1 << d);
            sg = SEG_TBL[data[4*d +: 4]];
            db = dp[d];
        end
        return {en, db, sg} ^ {12{inv}};
    endfunction

    task automatic push(input int k, input logic [11:0] exp);
        disp_t e;
        e.k   = k;
        e.exp = exp;
        dq.push_back(e);
    endtask

    task automatic drain(input string tag);
        disp_t e;
        while (dq.size() > 0) begin
            e = dq.pop_front();
            wait_k(e.k);
            chk($sformatf("%s_k%0d", tag, e.k), 32'({digit_en, dp_out, seg_out}), 32'(e.exp));
        end
    endtask

    task automatic start_scan(input logic [31:0] ctrl);
        wb_write(A_CTRL, ctrl, 4'hF);
        c0 = cyc_cnt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int on_cnt;
        int acks;
        bus_idle();

        // reset state and register readback
        do_reset();
        chk("rst_outputs", 32'({digit_en, dp_out, seg_out}), 32'h0);
        chk("rst_ack", 32'(wb.wbs_ack_o), 32'h0);
        wb_read(A_CTRL, 32'h0, "rst_ctrl");
        wb_read(A_PER,  32'h0, "rst_period");
        wb_read(A_DATA, 32'h0, "rst_data");
        wb_read(A_DP,   32'h0, "rst_dp");
        wb_read(A_STAT, 32'h0, "rst_status");
        @(posedge clk);
        #1;
        chk("ack_width", 32'(wb.wbs_ack_o), 32'h0);
        chk("dat_idle", wb.wbs_dat_o, 32'h0);

        wb_write(A_PER, 32'hFFFF_FFFF, 4'b0001);
        wb_read(A_PER, 32'h0000_00FF, "period_lane0");
        wb_write(A_DATA, 32'hABCD_4321, 4'hF);
        wb_read(A_DATA, 32'hABCD_4321, "data_full");
        wb_write(A_CTRL, 32'hFFFF_FF02, 4'b0010);
        wb_read(A_CTRL, 32'h0000_0F00, "ctrl_lane1");
        wb_write(A_STAT, 32'hFFFF_FFFF, 4'hF);
        wb_read(A_STAT, 32'h0, "status_ro");

        // normal scan, four digits, PERIOD 4
        do_reset();
        wb_write(A_DATA, 32'h0000_4321, 4'hF);
        wb_write(A_PER, 32'd4, 4'hF);
        for (int k = 1; k <= 30; k++) push(k, exp_out(k, 16'h4321, 4'h0, 4, 1'b0));
        start_scan(32'h0F01);
        drain("scan");
        wb_read(A_STAT, 32'h0000_0110, "scan_status");

        // brightness 3: 4 lit cycles out of every 16
        do_reset();
        wb_write(A_DATA, 32'h8, 4'hF);
        wb_write(A_PER, 32'd64, 4'hF);
        start_scan(32'h0301);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            wait_k(10 + i);
            chk("bright_en", 32'(digit_en), 32'h1);
            chk("bright_seg", 32'((seg_out == 7'h7F) || (seg_out == 7'h00)), 32'd1);
            if (seg_out == 7'h7F) on_cnt++;
        end
        chk("bright_duty", 32'(on_cnt), 32'd4);

        // invert for common-anode
        do_reset();
        wb_write(A_DATA, 32'h0, 4'hF);
        wb_write(A_DP, 32'h1, 4'hF);
        wb_write(A_PER, 32'd4, 4'hF);
        for (int k = 1; k <= 8; k++) push(k, exp_out(k, 16'h0000, 4'h1, 4, 1'b1));
        start_scan(32'h0F03);
        drain("invert");

        // DATA rewrite during digit 2's dwell
        do_reset();
        wb_write(A_DATA, 32'h0000_4321, 4'hF);
        wb_write(A_PER, 32'd4, 4'hF);
        start_scan(32'h0F01);
        for (int k = 20; k <= 23; k++) begin
`ifdef SEVEN_SEG_SHADOW_EN
            push(k, exp_out(k, 16'h4321, 4'h0, 4, 1'b0));
`else
            push(k, exp_out(k, 16'h5320, 4'h0, 4, 1'b0));
`endif
        end
        for (int k = 26; k <= 29; k++) push(k, exp_out(k, 16'h5320, 4'h0, 4, 1'b0));
        wait_k(13);
        wb_write(A_DATA, 32'h0000_5320, 4'hF);
        drain("shadow");

        // disable during digit 1's dwell
        do_reset();
        wb_write(A_DATA, 32'h0000_4321, 4'hF);
        wb_write(A_PER, 32'd4, 4'hF);
        start_scan(32'h0F01);
        push(8,  exp_out(8, 16'h4321, 4'h0, 4, 1'b0));
        push(9,  exp_out(9, 16'h4321, 4'h0, 4, 1'b0));
        push(10, 12'h000);
        push(11, 12'h000);
        wait_k(7);
        wb_write(A_CTRL, 32'h0F00, 4'hF);
        drain("disable");
        wb_read(A_STAT, 32'h0, "disable_status");

        // PERIOD shrunk to 1 while dwell count is 3
        do_reset();
        wb_write(A_DATA, 32'h0000_4321, 4'hF);
        wb_write(A_PER, 32'd64, 4'hF);
        start_scan(32'h0F01);
        push(5, {4'b0001, 1'b0, 7'h06});
        push(6, 12'h000);
        push(7, 12'h000);
        push(8, {4'b0010, 1'b0, 7'h5B});
        push(9, 12'h000);
        wait_k(3);
        wb_write(A_PER, 32'd1, 4'hF);
        drain("per_shrink");

        // unmapped address is never acknowledged
        @(negedge clk);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_adr_i = BASE + 32'h14;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o) acks++;
        end
        bus_idle();
        chk("unmapped_ack", 32'(acks), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
